// File: rtl/mips_uart_tx.sv
// UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN) fed by the MIPS debug unit.
// Bit timing from a 16x oversample tick derived from clk / BAUD_DVSR.
module mips_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DVSR = 163,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_tx_ready,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_tx,
    output logic                 o_tx_done
);

    localparam int BW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           r_state;
    logic [BW-1:0]        r_baud;
    logic [SW-1:0]        r_sample;
    logic [NW-1:0]        r_nbit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_tick;
    logic w_bit_end;
    logic w_stop_end;
    logic w_last_data;

    assign w_tick      = (r_baud == BW'(BAUD_DVSR - 1));
    assign w_bit_end   = w_tick && (r_sample == SW'(15));
    assign w_stop_end  = w_tick && (r_sample == SW'(SB_TICK - 1));
    assign w_last_data = (r_nbit == NW'(DATA_BITS - 1));

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;

    // Divider is parked at 0 while idle so every frame starts with identical timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_nbit   <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_done   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx     <= 1'b1;
                    r_done   <= 1'b1;
                    r_sample <= '0;
                    r_nbit   <= '0;
                    if (i_tx_ready) begin
                        r_state  <= S_START;
                        r_shift  <= i_tx_data;
                        r_tx     <= 1'b0;
                        r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^i_tx_data;
`endif
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_sample <= '0;
                        r_state  <= S_DATA;
                        r_tx     <= r_shift[0];
                    end else if (w_tick) begin
                        r_sample <= r_sample + SW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_sample <= '0;
                        r_shift  <= r_shift >> 1;
                        if (w_last_data) begin
                            r_nbit <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_nbit <= r_nbit + NW'(1);
                            r_tx   <= r_shift[1];
                        end
                    end else if (w_tick) begin
                        r_sample <= r_sample + SW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_sample <= '0;
                        r_state  <= S_STOP;
                        r_tx     <= 1'b1;
                    end else if (w_tick) begin
                        r_sample <= r_sample + SW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_stop_end) begin
                        r_sample <= '0;
                        r_state  <= S_IDLE;
                        r_done   <= 1'b1;
                    end else if (w_tick) begin
                        r_sample <= r_sample + SW'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sample <= '0;
                    r_nbit   <= '0;
                    r_tx     <= 1'b1;
                    r_done   <= 1'b1;
                end
            endcase
        end
    end

endmodule
